// File: rtl/display_capture.sv
// Receive-side monitor for a multiplexed 7-segment bus: captures stable digits, rebuilds 4-digit frames, decodes to hex.
// Latency: an/sseg settle -> shadow capture STABLE_CYCLES+1 cycles; frame outputs update 1 cycle after the digit-3 capture.
// Backpressure: none; the bus is observed passively and every event is reported as a single-cycle pulse or a level.
module display_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT_W     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] an,
    input  logic [7:0] sseg,
    output logic [7:0] dig3,
    output logic [7:0] dig2,
    output logic [7:0] dig1,
    output logic [7:0] dig0,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] hex_ok,
    output logic       frame_valid,
    output logic       seq_err,
    output logic       bad_an,
    output logic       stale
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    typedef enum logic {IDLE, SCAN} state_t;

    // Registers
    logic [7:0]           r_an_s, r_sseg_s;
    logic [7:0]           r_an_p, r_sseg_p;
    logic [7:0]           r_cnt;
    logic [3:0][7:0]      r_shadow;
    state_t               r_state;
    logic [1:0]           r_expect;
    logic                 r_pub_pend;
    logic [3:0][7:0]      r_dig;
    logic [3:0][3:0]      r_hex;
    logic [3:0]           r_ok;
    logic                 r_fv, r_seq, r_bad;
    logic [TIMEOUT_W-1:0] r_to;

    // Wires
    logic                 w_same, w_stable, w_capture;
    logic                 w_legal, w_blank;
    logic [1:0]           w_idx;
    state_t               w_state_nxt;
    logic [1:0]           w_expect_nxt;
    logic                 w_pub_set, w_seq, w_bad;
    logic [3:0][3:0]      w_hex;
    logic [3:0]           w_ok;

    // Glyph lookup on segments a..g; dp is don't-care. Returns {match, nibble}.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40: r = 5'h10;
            7'h79: r = 5'h11;
            7'h24: r = 5'h12;
            7'h30: r = 5'h13;
            7'h19: r = 5'h14;
            7'h12: r = 5'h15;
            7'h02: r = 5'h16;
            7'h78: r = 5'h17;
            7'h00: r = 5'h18;
            7'h10: r = 5'h19;
            7'h08: r = 5'h1A;
            7'h03: r = 5'h1B;
            7'h46: r = 5'h1C;
            7'h21: r = 5'h1D;
            7'h06: r = 5'h1E;
            7'h0E: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Register the bus, and keep one older sample to detect a dwell
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an_s   <= 8'hFF;
            r_sseg_s <= 8'hFF;
            r_an_p   <= 8'hFF;
            r_sseg_p <= 8'hFF;
        end else begin
            r_an_s   <= an;
            r_sseg_s <= sseg;
            r_an_p   <= r_an_s;
            r_sseg_p <= r_sseg_s;
        end
    end

    assign w_same   = ({r_an_s, r_sseg_s} == {r_an_p, r_sseg_p});
    // Fires only on the step into saturation, so once per dwell
    assign w_stable = w_same && (r_cnt == STABLE_C - 8'd1);

    // Dwell counter: saturating run length of identical samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'd0;
        end else if (!w_same) begin
            r_cnt <= 8'd1;
        end else if (r_cnt != STABLE_C) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Classify the sampled digit enable
    always_comb begin
        w_legal = 1'b0;
        w_blank = 1'b0;
        w_idx   = 2'd0;
        case (r_an_s)
            8'b1110_1111: begin w_legal = 1'b1; w_idx = 2'd0; end
            8'b1101_1111: begin w_legal = 1'b1; w_idx = 2'd1; end
            8'b1011_1111: begin w_legal = 1'b1; w_idx = 2'd2; end
            8'b0111_1111: begin w_legal = 1'b1; w_idx = 2'd3; end
            8'b1111_1111: w_blank = 1'b1;
            default: ;
        endcase
    end

    assign w_capture = w_stable && w_legal;

    // Shadow store: latest stable pattern for each digit position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow <= {4{8'hFF}};
        end else if (w_capture) begin
            r_shadow[w_idx] <= r_sseg_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_expect <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_expect <= w_expect_nxt;
        end
    end

    // FSM next state: track digit order, flag ordering and enable errors
    always_comb begin
        w_state_nxt  = r_state;
        w_expect_nxt = r_expect;
        w_pub_set    = 1'b0;
        w_seq        = 1'b0;
        w_bad        = 1'b0;
        if (w_capture) begin
            if (r_state == IDLE) begin
                if (w_idx == 2'd0) begin
                    w_state_nxt  = SCAN;
                    w_expect_nxt = 2'd1;
                end
            end else if (w_idx == r_expect) begin
                if (r_expect == 2'd3) begin
                    w_pub_set    = 1'b1;
                    w_state_nxt  = IDLE;
                    w_expect_nxt = 2'd0;
                end else begin
                    w_expect_nxt = r_expect + 2'd1;
                end
            end else begin
                w_seq = 1'b1;
                if (w_idx == 2'd0) begin
                    w_state_nxt  = SCAN;
                    w_expect_nxt = 2'd1;
                end else begin
                    w_state_nxt  = IDLE;
                    w_expect_nxt = 2'd0;
                end
            end
        end else if (w_stable && !w_blank) begin
            w_bad        = 1'b1;
            w_state_nxt  = IDLE;
            w_expect_nxt = 2'd0;
        end
    end

    // Decode every shadow slot; consumed only at publish time
    always_comb begin
        w_hex = '0;
        w_ok  = '0;
        for (int k = 0; k < 4; k++) begin
            {w_ok[k], w_hex[k]} = f_decode(r_shadow[k][6:0]);
        end
    end

    // Publish a complete frame one cycle after the digit-3 capture; pulse flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pub_pend <= 1'b0;
            r_dig      <= {4{8'hFF}};
            r_hex      <= '0;
            r_ok       <= '0;
            r_fv       <= 1'b0;
            r_seq      <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            r_pub_pend <= w_pub_set;
            r_fv       <= r_pub_pend;
            r_seq      <= w_seq;
            r_bad      <= w_bad;
            if (r_pub_pend) begin
                r_dig <= r_shadow;
                r_hex <= w_hex;
                r_ok  <= w_ok;
            end
        end
    end

    // Inactivity counter: cleared by any capture, saturates at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to <= '0;
        end else if (w_capture) begin
            r_to <= '0;
        end else if (!(&r_to)) begin
            r_to <= r_to + 1'b1;
        end
    end

    assign dig3        = r_dig[3];
    assign dig2        = r_dig[2];
    assign dig1        = r_dig[1];
    assign dig0        = r_dig[0];
    assign hex3        = r_hex[3];
    assign hex2        = r_hex[2];
    assign hex1        = r_hex[1];
    assign hex0        = r_hex[0];
    assign hex_ok      = r_ok;
    assign frame_valid = r_fv;
    assign seq_err     = r_seq;
    assign bad_an      = r_bad;
    assign stale       = &r_to;

endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
- Receive-side monitor for the multiplexed 7-segment bus produced by the board's display scanner.
- Samples the active-low digit enables and segment bus, captures each digit's pattern once it has been stable, and reassembles complete four-digit frames.
- Decodes each pattern back to a hex nibble and flags protocol errors.
- Used for loopback self-test and for on-chip checking of the display path.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples of an/sseg required before a digit is captured; legal range 2..255.
- TIMEOUT_W, 20: width of the inactivity counter; stale asserts after 2^TIMEOUT_W-1 cycles without a capture.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- an  in  8  digit enables, active-low; legal active values 11101111 (digit 0), 11011111 (digit 1), 10111111 (digit 2), 01111111 (digit 3); 11111111 = blank
- sseg  in  8  segment bus {dp,g,f,e,d,c,b,a}, active-low
- dig3, dig2, dig1, dig0  out  8 each  raw captured patterns of the last complete frame
- hex3, hex2, hex1, hex0  out  4 each  decoded nibble per digit
- hex_ok  out  4  bit k = 1 if digk matched a hex glyph
- frame_valid  out  1  one-cycle pulse when the frame outputs update
- seq_err  out  1  one-cycle pulse on an out-of-order digit
- bad_an  out  1  one-cycle pulse on a stable illegal enable pattern
- stale  out  1  level; no capture for 2^TIMEOUT_W-1 cycles

Behaviour:
- Reset (reset = 0, asynchronous):
  - dig* = 8'hFF; hex* = 0; hex_ok = 0.
  - frame_valid, seq_err, bad_an, stale = 0.
  - Shadow registers = 8'hFF; FSM = IDLE; all counters = 0.
- Sample stage: an and sseg are registered each cycle into an_s and sseg_s. All later logic uses only the sampled values.
- Stability counter:
  - If {an_s, sseg_s} equals the previous sample, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the counter loads 1.
  - The stable event fires exactly once per dwell, on the edge where the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES.
- Classification at the stable event:
  - Legal digit k: capture sseg_s into shadow[k].
  - Blank (8'hFF): ignored; no capture, no error.
  - Any other value: pulse bad_an, no capture, FSM goes to IDLE.
- FSM states: IDLE and SCAN, with expect[1:0] holding the next digit index.
  - IDLE: a capture of digit 0 moves to SCAN with expect = 1. A capture of any other digit is discarded silently.
  - SCAN, capture of digit == expect: if expect < 3, increment expect.
  - SCAN, capture of digit == expect == 3: publish the frame and go to IDLE.
  - SCAN, capture of digit != expect: pulse seq_err. If that digit is 0, restart SCAN with expect = 1 and keep the new shadow[0]; otherwise go to IDLE.
- Publish: on the edge after the digit-3 capture, all of the following update together:
  - dig* <= shadow*.
  - hex* and hex_ok are decoded from shadow*.
  - frame_valid = 1 for that one cycle.
  - Outputs hold their values between publishes.
- Decode:
  - Uses bits [6:0] only; dp is ignored.
  - Glyph table 0..F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
  - No match gives hex = 0 and hex_ok[k] = 0.
- Latency: from an/sseg settling to shadow capture is STABLE_CYCLES+1 cycles. frame_valid follows the digit-3 capture by 1 cycle.
- Timeout:
  - The counter clears on every capture and otherwise increments, saturating at all-ones.
  - stale = 1 while saturated; it drops on the cycle after the next capture.
  - The timeout never alters FSM state.
- Simultaneous events: bad_an and seq_err cannot coincide, because there is at most one stable event per cycle. A publish and a new capture cannot occur in the same cycle when STABLE_CYCLES >= 2.
- Mid-operation reset: all state is discarded immediately. After release, the first frame must begin with digit 0.

Test Plan:
- Normal scan: drive digits 0..3 with patterns C0, F9, A4, B0, dwell 8 cycles each (STABLE_CYCLES = 4). Required: frame_valid pulses once after the digit-3 capture; dig0..3 = C0, F9, A4, B0; hex0..3 = 0, 1, 2, 3; hex_ok = 1111.
- Glitch rejection: digit-1 dwell of only 3 cycles inside a scan. Required: no capture of digit 1; the following digit-2 capture raises seq_err; no frame_valid for that scan.
- Unknown glyph plus dp: digit 2 = 0x7F, digit 0 = 0x40 (dp on). Required: hex_ok = 1011, hex2 = 0, hex0 = 0, dig0 = 40.
- Illegal enable: an = 11100111 held 6 cycles mid-scan. Required: one bad_an pulse; FSM returns to IDLE; the next full scan publishes normally.
- Timeout: TIMEOUT_W = 4, an held at FF for 20 cycles. Required: stale = 1 from cycle 15 after the last capture; stale clears one cycle after the next capture.
- Reset mid-frame: assert reset after digit 1 is captured. Required: all outputs return to reset values asynchronously; after release, digits 2 and 3 alone do not publish.
